uart_tx_arbiter: RTL and testbench

- Shares one `uart_tx` byte transmitter among N requesters.
- Each requester offers bytes over a valid/ready handshake. The arbiter picks one requester round-robin and registers its byte.
- It then pulses `uart_tx`'s `en` with that byte and tracks `busy` until the frame has left the line.
- Sits between on-chip byte producers (debug log, command responder, etc.) and the single `uart_tx` instance.

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the FSM state encoding and round-robin pointer arithmetic.
package uart_arb_pkg;

  localparam int DW_DEF      = 8;
  localparam int BUSY_TO_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } arb_state_t;

  function automatic int rr_next(
    input int ptr,
    input int n
  );
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin pick starting at i_ptr, wrapping modulo NREQ.
// A set i_lock restricts the pick to i_lock_id only.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_lock,
  input  logic [IW-1:0]   i_lock_id,
  output logic            o_any,
  output logic [IW-1:0]   o_win,
  output logic [NREQ-1:0] o_gnt
);

  always_comb begin
    o_any = 1'b0;
    o_win = '0;
    if (i_lock) begin
      o_any = i_req[i_lock_id];
      o_win = i_lock_id;
    end else begin
      // walk backwards so the closest index to i_ptr wins
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (i_req[IW'((int'(i_ptr) + i) % NREQ)]) begin
          o_any = 1'b1;
          o_win = IW'((int'(i_ptr) + i) % NREQ);
        end
      end
    end
    o_gnt = o_any ? (NREQ'(1) << o_win) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte producers.
// Define UART_ARB_LOCK_EN to keep the grant until a req_last byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = DW_DEF,
  parameter int BUSY_TO = BUSY_TO_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_en,
  output logic [DW-1:0]           tx_data,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    active,
  output logic                    err_to
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BUSY_TO) + 1;

  arb_state_t r_state;
  arb_state_t w_next;

  logic [DW-1:0]   r_tx_data;
  logic [IW-1:0]   r_grant_id;
  logic [IW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_err_to;

  logic            w_any;
  logic [IW-1:0]   w_win;
  logic [NREQ-1:0] w_gnt;
  logic            w_lock;
  logic            w_accept;
  logic            w_to;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .i_lock    (w_lock),
    .i_lock_id (r_grant_id),
    .o_any     (w_any),
    .o_win     (w_win),
    .o_gnt     (w_gnt)
  );

  // gated by rst so nothing is offered while reset is held
  assign w_accept = rst && (r_state == IDLE) && !tx_busy && w_any;

  assign w_to = (r_state == WAIT_HI) && !tx_busy &&
                (r_cnt == CW'(BUSY_TO - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = ISSUE;
      ISSUE:   w_next = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy)   w_next = WAIT_LO;
        else if (w_to) w_next = IDLE;
      end
      WAIT_LO: if (!tx_busy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    tx_en     = (r_state == ISSUE);
    active    = (r_state != IDLE);
    req_ready = w_accept ? w_gnt : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_data  <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_err_to   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tx_data  <= req_data[int'(w_win)*DW +: DW];
        r_grant_id <= w_win;
        r_rr_ptr   <= IW'(rr_next(int'(w_win), NREQ));
      end
      if (r_state == ISSUE)
        r_cnt <= '0;
      else if (r_state == WAIT_HI && !tx_busy && !w_to)
        r_cnt <= r_cnt + 1'b1;
      if (w_to)
        r_err_to <= 1'b1;
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_lock <= 1'b0;
    else if (w_to)     r_lock <= 1'b0;
    else if (w_accept) r_lock <= !req_last[w_win];
  end

  assign w_lock = r_lock;
`else
  logic w_unused_last;

  assign w_unused_last = ^req_last;
  assign w_lock        = 1'b0;
`endif

  assign tx_data  = r_tx_data;
  assign grant_id = r_grant_id;
  assign err_to   = r_err_to;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a hand-driven uart_tx busy stub.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_en;
  logic [DW-1:0]        tx_data;
  logic                 tx_busy;
  logic [1:0]           grant_id;
  logic                 active;
  logic                 err_to;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .BUSY_TO (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active),
    .err_to    (err_to)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic one_frame(
    input int          id,
    input logic [7:0]  d,
    input bit          drop
  );
    #1;
    check("ready_onehot", 32'(req_ready), 32'(1) << id);
    @(negedge clk);
    if (drop) req_valid[id] = 1'b0;
    #1;
    check("issue_en",    32'(tx_en),     32'd1);
    check("issue_data",  32'(tx_data),   32'(d));
    check("issue_gid",   32'(grant_id),  32'(id));
    check("issue_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    tx_busy = 1'b1;
    #1;
    check("en_pulse", 32'(tx_en), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("busy_active", 32'(active),  32'd1);
    check("busy_data",   32'(tx_data), 32'(d));
    tx_busy = 1'b0;
    @(negedge clk);
    #1;
    check("active_fall", 32'(active), 32'd0);
  endtask

  initial begin
    req_data = '0;
    do_reset();

    // reset state and all-valids-low idle
    #1;
    check("rst_en",     32'(tx_en),     32'd0);
    check("rst_data",   32'(tx_data),   32'd0);
    check("rst_ready",  32'(req_ready), 32'd0);
    check("rst_gid",    32'(grant_id),  32'd0);
    check("rst_active", 32'(active),    32'd0);
    check("rst_err",    32'(err_to),    32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("idle_stay", 32'(active), 32'd0);

    // single byte from requester 2
    req_valid[2]     = 1'b1;
    req_data[16 +: 8] = 8'hA5;
    one_frame(2, 8'hA5, 1'b1);

    // round robin with all four continuously valid
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = 8'(8'h10 + i);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) one_frame(k % 4, 8'(8'h10 + k % 4), 1'b0);
    req_valid = '0;

    // blocked start while uart_tx reports busy
    do_reset();
    tx_busy = 1'b1;
    req_valid[1]     = 1'b1;
    req_data[8 +: 8] = 8'h3C;
    #1;
    check("blk_ready0", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    check("blk_ready1", 32'(req_ready), 32'd0);
    check("blk_active", 32'(active),    32'd0);
    tx_busy = 1'b0;
    one_frame(1, 8'h3C, 1'b1);

    // busy never rises: timeout after 16 WAIT_HI cycles
    req_valid[3]      = 1'b1;
    req_data[24 +: 8] = 8'h5A;
    #1;
    check("to_ready", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    #1;
    check("to_en", 32'(tx_en), 32'd1);
    repeat (16) @(negedge clk);
    #1;
    check("to_err_pre",    32'(err_to), 32'd0);
    check("to_active_pre", 32'(active), 32'd1);
    @(negedge clk);
    #1;
    check("to_err",    32'(err_to), 32'd1);
    check("to_active", 32'(active), 32'd0);
    // rr_ptr wrapped from 3 to 0
    req_valid[0]     = 1'b1;
    req_data[0 +: 8] = 8'h77;
    one_frame(0, 8'h77, 1'b1);
    check("err_sticky", 32'(err_to), 32'd1);

    // reset in WAIT_LO with two requesters pending
    req_valid[1]     = 1'b1;
    req_data[8 +: 8] = 8'h99;
    #1;
    check("mid_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("mid_active", 32'(active), 32'd1);
    req_valid         = 4'b1010;
    req_data[24 +: 8] = 8'hEE;
    #2;
    rst = 1'b0;
    #1;
    check("arst_en",     32'(tx_en),     32'd0);
    check("arst_data",   32'(tx_data),   32'd0);
    check("arst_ready",  32'(req_ready), 32'd0);
    check("arst_gid",    32'(grant_id),  32'd0);
    check("arst_active", 32'(active),    32'd0);
    check("arst_err",    32'(err_to),    32'd0);
    tx_busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    one_frame(1, 8'h99, 1'b1);
    req_valid = '0;

    // two requesters with packet marks
    do_reset();
    req_data[0 +: 8] = 8'hA0;
    req_data[8 +: 8] = 8'hB1;
    req_last         = 4'b0001;
    req_valid[0]     = 1'b1;
    one_frame(0, 8'hA0, 1'b1);
    req_valid = 4'b0011;
`ifdef UART_ARB_LOCK_EN
    one_frame(1, 8'hB1, 1'b0);
    one_frame(1, 8'hB1, 1'b0);
    req_last[1] = 1'b1;
    one_frame(1, 8'hB1, 1'b0);
    one_frame(0, 8'hA0, 1'b0);
`else
    one_frame(1, 8'hB1, 1'b0);
    one_frame(0, 8'hA0, 1'b0);
    req_last[1] = 1'b1;
    one_frame(1, 8'hB1, 1'b0);
    one_frame(0, 8'hA0, 1'b0);
`endif
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
